// File: rtl/uart_rx_fifo_writer.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_writer
//
// UART receive deserializer that feeds the write port of an async FIFO. It runs
// entirely in the FIFO write clock domain. The serial line is oversampled at
// P_CLKS_PER_BIT clocks per bit. Each character is framed as 8N1, LSB first.
// Each good byte is pushed with a single-cycle write strobe, gated by FIFO full.
// Framing errors, overruns and, optionally, parity errors are reported on
// sticky flags.
//
// Optional feature (compile-time macro UART_RX_PARITY_EN):
//   defined   - one even-parity bit follows the data bits (8E1). A mismatch
//               sets o_parity_err and drops the byte.
//   undefined - plain 8N1 framing; o_parity_err is tied to 0.
//
// Parameters:
//   P_DATA_WIDTH   data bits per character, also FIFO write-data width (>= 2)
//   P_CLKS_PER_BIT i_wr_clk cycles per bit (>= 4)
//
// Ports:
//   i_wr_clk        write-domain clock
//   i_wr_rst_n      asynchronous active-low reset
//   i_rx            serial input, asynchronous to i_wr_clk, idle high
//   i_fifo_full     FIFO full flag (write domain)
//   i_clr_err       synchronous clear of the sticky error flags
//   o_fifo_wr_en    one-cycle FIFO write strobe
//   o_fifo_wr_data  received byte, valid while o_fifo_wr_en is high; it holds
//                   the last pushed value otherwise
//   o_busy          receiver is not in IDLE
//   o_frame_err     sticky: stop bit sampled low
//   o_overrun       sticky: good byte dropped because the FIFO was full
//   o_parity_err    sticky: parity mismatch (only with UART_RX_PARITY_EN)
// -----------------------------------------------------------------------------
module uart_rx_fifo_writer #(
    parameter int P_DATA_WIDTH   = 8,
    parameter int P_CLKS_PER_BIT = 868
) (
    input  logic                    i_wr_clk,
    input  logic                    i_wr_rst_n,
    input  logic                    i_rx,
    input  logic                    i_fifo_full,
    input  logic                    i_clr_err,
    output logic                    o_fifo_wr_en,
    output logic [P_DATA_WIDTH-1:0] o_fifo_wr_data,
    output logic                    o_busy,
    output logic                    o_frame_err,
    output logic                    o_overrun,
    output logic                    o_parity_err
);

    localparam int P_CNT_WIDTH = $clog2(P_CLKS_PER_BIT);
    localparam int P_BIT_WIDTH = $clog2(P_DATA_WIDTH);

    // Terminal counts. The start bit is sampled after half a bit time, so
    // every later sample lands near the middle of its bit.
    localparam logic [P_CNT_WIDTH-1:0] P_HALF_LAST = P_CNT_WIDTH'(P_CLKS_PER_BIT / 2 - 1);
    localparam logic [P_CNT_WIDTH-1:0] P_FULL_LAST = P_CNT_WIDTH'(P_CLKS_PER_BIT - 1);
    localparam logic [P_BIT_WIDTH-1:0] P_LAST_BIT  = P_BIT_WIDTH'(P_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer
    // -------------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    // NOTE: both flops reset to the idle level. After reset the receiver then
    // sees a quiet line, not a false start edge.
    always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
        if (!i_wr_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Receiver state
    // -------------------------------------------------------------------------
    state_t                    state_q;
    logic [P_CNT_WIDTH-1:0]    baud_cnt_q;
    logic [P_BIT_WIDTH-1:0]    bit_cnt_q;
    logic [P_DATA_WIDTH-1:0]   shift_q;
    logic                      break_q;      // line was low at the stop bit; wait for high
    logic                      fifo_wr_en_q;
    logic [P_DATA_WIDTH-1:0]   fifo_wr_data_q;
    logic                      frame_err_q;
    logic                      overrun_q;

    logic                      baud_done;
    logic                      stop_sample;
    logic                      char_ok;
    logic                      push_d;
    logic                      frame_err_d;
    logic                      overrun_d;

`ifdef UART_RX_PARITY_EN
    logic                      parity_bad_q;
    logic                      parity_err_q;
    logic                      parity_sample;
    logic                      parity_err_d;
`endif

    // -------------------------------------------------------------------------
    // Sample points, push decision and sticky-flag next state
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first. Later ifs only
    // override the default, so no path can infer a latch.
    always_comb begin
        baud_done   = 1'b0;
        stop_sample = 1'b0;
        char_ok     = 1'b0;
        push_d      = 1'b0;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (state_q == ST_START) begin
            baud_done = (baud_cnt_q == P_HALF_LAST);
        end else begin
            baud_done = (baud_cnt_q == P_FULL_LAST);
        end

        stop_sample = (state_q == ST_STOP) && baud_done;

`ifdef UART_RX_PARITY_EN
        char_ok = rx_s_q && !parity_bad_q;
`else
        char_ok = rx_s_q;
`endif

        // i_fifo_full matters only on the stop-sample cycle.
        push_d = stop_sample && char_ok && !i_fifo_full;

        // A clear is applied first, so a set event in the same cycle wins.
        if (i_clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (stop_sample && !rx_s_q) begin
            frame_err_d = 1'b1;
        end
        if (stop_sample && char_ok && i_fifo_full) begin
            overrun_d = 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_comb begin
        parity_sample = (state_q == ST_PARITY) && baud_done;
        parity_err_d  = parity_err_q;
        if (i_clr_err) begin
            parity_err_d = 1'b0;
        end
        // Even parity: data bits XOR the parity bit must be 0.
        if (parity_sample && (^{shift_q, rx_s_q})) begin
            parity_err_d = 1'b1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // FSM, counters, shift register and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from values sampled before the clock edge.
    always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
        if (!i_wr_rst_n) begin
            state_q        <= ST_IDLE;
            baud_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            break_q        <= 1'b0;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= '0;
            frame_err_q    <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q   <= 1'b0;
            parity_err_q   <= 1'b0;
`endif
        end else begin
            fifo_wr_en_q <= push_d;
            if (push_d) begin
                fifo_wr_data_q <= shift_q;
            end
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif

            case (state_q)
                ST_IDLE: begin
                    if (break_q) begin
                        // After a low stop bit the line must return high
                        // before a new falling edge counts as a start.
                        if (rx_s_q) begin
                            break_q <= 1'b0;
                        end
                    end else if (!rx_s_q) begin
                        baud_cnt_q <= '0;
                        state_q    <= ST_START;
                    end
                end

                ST_START: begin
                    if (baud_done) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        // A line that is high again at mid-start is a glitch.
                        state_q    <= rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt_q <= '0;
                        // Shift right: the first bit received ends up in bit 0.
                        shift_q    <= {rx_s_q, shift_q[P_DATA_WIDTH-1:1]};
                        if (bit_cnt_q == P_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (baud_done) begin
                        baud_cnt_q   <= '0;
                        parity_bad_q <= ^{shift_q, rx_s_q};
                        state_q      <= ST_STOP;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt_q <= '0;
                        break_q    <= !rx_s_q;
                        state_q    <= ST_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_fifo_wr_en   = fifo_wr_en_q;
    assign o_fifo_wr_data = fifo_wr_data_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_frame_err    = frame_err_q;
    assign o_overrun      = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err   = parity_err_q;
`else
    assign o_parity_err   = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo_writer.md
Name: uart_rx_fifo_writer

Overview:
- Producer-side block for the async FIFO write port: UART receive deserializer running in the write clock domain.
- Oversamples the serial line, frames 8N1 characters LSB-first, and pushes each good byte into the FIFO with a one-cycle write strobe gated by FIFO full.
- Detects and reports framing errors and overruns. The FIFO's read side delivers bytes to the host/I2C clock domain.

Parameters:
- P_DATA_WIDTH, 8, data bits per character; also FIFO write-data width.
- P_CLKS_PER_BIT, 868, i_wr_clk cycles per bit (100 MHz / 115200); minimum 4.
- P_CNT_WIDTH, $clog2(P_CLKS_PER_BIT), baud counter width (localparam).

Ports:
- i_wr_clk  in  1  write-domain clock.
- i_wr_rst_n  in  1  reset, asynchronous, active-low.
- i_rx  in  1  serial input, asynchronous to i_wr_clk, idle high.
- i_fifo_full  in  1  FIFO o_full, same domain.
- i_clr_err  in  1  synchronous clear of sticky error flags.
- o_fifo_wr_en  out  1  one-cycle write strobe to FIFO i_wr_en.
- o_fifo_wr_data  out  P_DATA_WIDTH  received byte, valid while o_fifo_wr_en=1.
- o_busy  out  1  high in any state other than IDLE.
- o_frame_err  out  1  sticky: stop bit sampled low.
- o_overrun  out  1  sticky: byte dropped because FIFO full.
- o_parity_err  out  1  sticky parity mismatch (see Optional Feature).

Behaviour:
- Reset values: o_fifo_wr_en=0, o_fifo_wr_data=0, o_busy=0, all error flags=0, FSM=IDLE, baud counter=0, bit counter=0.
- Reset is effective mid-frame: a partial byte is discarded and never pushed.
- Input sync:
  - i_rx passes through a 2-flop synchronizer; both flops reset to 1.
  - All decisions use the second-flop output, rx_s.
- FSM states and transitions:
  - IDLE: on rx_s==0, clear the baud counter and go to START.
  - START: count P_CLKS_PER_BIT/2 (integer division) cycles, then sample rx_s. If 0, go to DATA with bit counter=0. If 1, treat as a glitch and return to IDLE with no flag.
  - DATA: count P_CLKS_PER_BIT cycles, then sample rx_s into the shift register. Shift right, so the first sampled bit lands in bit 0. After P_DATA_WIDTH samples, go to STOP.
  - STOP: count P_CLKS_PER_BIT cycles, then sample rx_s and go to IDLE.
- Stop-bit outcomes:
  - Stop=1 and i_fifo_full=0: on the next cycle o_fifo_wr_en=1 for exactly one cycle, with o_fifo_wr_data = assembled byte.
  - Stop=1 and i_fifo_full=1: byte dropped, no strobe, o_overrun set.
  - Stop=0: byte dropped, no strobe, o_frame_err set. A line held low (break) does not re-trigger until rx_s returns to 1 and falls again.
- i_fifo_full is sampled only on the stop-sample cycle.
- Latency: the strobe rises 1 cycle after the stop-bit mid-point sample, i.e. about 9.5 bit times after the start edge plus 2 sync cycles.
- Back-to-back: after STOP, IDLE accepts a new start edge on the very next cycle. Zero idle time between frames must work.
- o_fifo_wr_data holds its last pushed value between strobes.
- Sticky flags:
  - Cleared only by reset or i_clr_err=1.
  - If i_clr_err and a set event happen in the same cycle, set wins.
- Baud counter wraps to 0 at each sample point; there is no cumulative drift.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting one bit time. It samples an even-parity bit: XOR of the data bits and the parity bit must be 0.
  - On mismatch, o_parity_err is set and the byte is dropped, even if the stop bit is good.
  - A frame error still sets o_frame_err independently.
  - Latency increases by one bit time.
- Undefined:
  - Frame is 8N1 and no PARITY state exists.
  - o_parity_err is tied to 0.

Test Plan:
- Test parameters: P_CLKS_PER_BIT=16, P_DATA_WIDTH=8.
1. Send 0xA5 (8N1) with full=0 -> single o_fifo_wr_en pulse, data=0xA5, all flags 0, o_busy low after the stop sample.
2. Send 0x00 then 0xFF with zero idle gap -> two pulses in order, data 0x00 then 0xFF, 160 cycles apart.
3. Drive i_rx low for 4 cycles on an idle line -> no strobe, FSM returns to IDLE, no flags; a following 0x3C is received correctly.
4. Send 0x3C with stop bit=0 -> no strobe, o_frame_err=1 and held; pulse i_clr_err -> 0.
5. Hold i_fifo_full=1 and send 0x55 -> no strobe, o_overrun=1. Release full and send 0x66 -> pushed, o_overrun still 1.
6. Assert i_wr_rst_n low during bit 4 of 0x81 -> all outputs at reset values, no strobe; the next clean 0x81 is pushed. With UART_RX_PARITY_EN, 0x81 with parity=1 -> o_parity_err=1, no strobe.
